// File: rtl/imm_gen_pipe.sv
// Registered, handshaked RV32I immediate decoder with a saturating illegal-opcode counter.
// Optional: define IMMGEN_SKID_EN to add a 1-entry skid buffer and a registered in_ready.
module imm_gen_pipe #(
    parameter int INTRSIZE = 32,
    parameter int IMMSIZE  = 32,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INTRSIZE-1:0] instruction,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IMMSIZE-1:0]  immediate,
    output logic [2:0]          imm_fmt,
    output logic                illegal,
    output logic [CNT_W-1:0]    illegal_cnt
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        d.imm = '0;
        d.fmt = FMT_NONE;
        d.ill = 1'b0;
        case (i[6:0])
            OPC_OP_IMM: begin
                if (i[13:12] == 2'b01) begin
                    d.imm = {27'b0, i[24:20]};
                    d.fmt = FMT_SHAMT;
                end else begin
                    d.imm = {{20{i[31]}}, i[31:20]};
                    d.fmt = FMT_I;
                end
            end
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                d.imm = {{20{i[31]}}, i[31:20]};
                d.fmt = FMT_I;
            end
            OPC_STORE: begin
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                d.fmt = FMT_S;
            end
            OPC_BRANCH: begin
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                d.fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                d.imm = {i[31:12], 12'b0};
                d.fmt = FMT_U;
            end
            OPC_JAL: begin
                d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                d.fmt = FMT_J;
            end
            OPC_OP, OPC_FENCE: begin
                d.ill = 1'b0;
            end
            default: begin
                d.ill = 1'b1;
            end
        endcase
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    dec_t             dec_in;
    logic             accept;
    logic             in_ready_int;
    logic             out_valid_q, out_valid_d;
    dec_t             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [31:0] imm_s;

`ifdef IMMGEN_SKID_EN
    logic skid_full_q, skid_full_d;
    dec_t skid_q, skid_d;

    // Skid entry, when full, is always older than anything at the input, so it drains first.
    always_comb begin
        dec_in       = decode(instruction[31:0]);
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_full_d  = skid_full_q;
        skid_d       = skid_q;
        cnt_d        = cnt_q;
        in_ready_int = !skid_full_q;
        accept       = in_valid && in_ready_int;
        if (skid_full_q) begin
            if (out_ready) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                out_d       = dec_in;
                out_valid_d = 1'b1;
            end else begin
                skid_d      = dec_in;
                skid_full_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && dec_in.ill) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_full_q <= 1'b0;
        end else begin
            skid_full_q <= skid_full_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end
`else
    always_comb begin
        dec_in       = decode(instruction[31:0]);
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        cnt_d        = cnt_q;
        in_ready_int = !out_valid_q || out_ready;
        accept       = in_valid && in_ready_int;
        if (accept) begin
            out_d       = dec_in;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && dec_in.ill) begin
            cnt_d = sat_inc(cnt_q);
        end
    end
`endif

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
        end
    end

    assign imm_s       = out_q.imm;
    assign immediate   = IMMSIZE'(imm_s);
    assign imm_fmt     = out_q.fmt;
    assign illegal     = out_q.ill;
    assign out_valid   = out_valid_q;
    assign illegal_cnt = cnt_q;
    assign in_ready    = in_ready_int;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table plus stall, saturation and reset sequences.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instruction;

    logic        in_ready, out_valid, illegal;
    logic [31:0] immediate;
    logic [2:0]  imm_fmt;
    logic [7:0]  illegal_cnt;

    logic        in_ready2, out_valid2, illegal2;
    logic [39:0] immediate2;
    logic [2:0]  imm_fmt2;
    logic [1:0]  illegal_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    imm_gen_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .immediate(immediate), .imm_fmt(imm_fmt), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.IMMSIZE(40), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .instruction(instruction), .out_valid(out_valid2), .out_ready(out_ready),
        .immediate(immediate2), .imm_fmt(imm_fmt2), .illegal(illegal2),
        .illegal_cnt(illegal_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [31:0] imm, input logic [2:0] fmt,
                           input logic ill);
        chk({nm, " out_valid"}, 64'(out_valid), 64'(1'b1));
        chk({nm, " imm"}, 64'(immediate), 64'(imm));
        chk({nm, " fmt"}, 64'(imm_fmt), 64'(fmt));
        chk({nm, " illegal"}, 64'(illegal), 64'(ill));
        chk({nm, " imm40"}, 64'(immediate2), 64'({{8{imm[31]}}, imm}));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int cnt;

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        instruction = '0;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0};
        vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
        vecs[3]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0};
        vecs[4]  = '{32'h0010006F, 32'h00000800, 3'd5, 1'b0};
        vecs[5]  = '{32'h40515093, 32'h00000005, 3'd6, 1'b0};
        vecs[6]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1};
        vecs[7]  = '{32'h00000033, 32'h00000000, 3'd0, 1'b0};
        vecs[8]  = '{32'h0000000F, 32'h00000000, 3'd0, 1'b0};
        vecs[9]  = '{32'h00A12083, 32'h0000000A, 3'd1, 1'b0};
        vecs[10] = '{32'h80000067, 32'hFFFFF800, 3'd1, 1'b0};
        vecs[11] = '{32'h00000073, 32'h00000000, 3'd1, 1'b0};
        vecs[12] = '{32'h80000017, 32'h80000000, 3'd4, 1'b0};
        vecs[13] = '{32'h00100093, 32'h00000001, 3'd1, 1'b0};
        vecs[14] = '{32'h7FF0A0A3, 32'h000007E1, 3'd2, 1'b0};
        vecs[15] = '{32'h8000006F, 32'hFFF00000, 3'd5, 1'b0};
        vecs[16] = '{32'h7E000FE3, 32'h00000FFE, 3'd3, 1'b0};
        vecs[17] = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1};
        vecs[18] = '{32'h00201013, 32'h00000002, 3'd6, 1'b0};
        vecs[19] = '{32'h01F0D093, 32'h0000001F, 3'd6, 1'b0};

        // Reset state
        @(negedge clk);
        do_reset();
        chk("rst out_valid", 64'(out_valid), 64'(0));
        chk("rst imm", 64'(immediate), 64'(0));
        chk("rst fmt", 64'(imm_fmt), 64'(0));
        chk("rst illegal", 64'(illegal), 64'(0));
        chk("rst cnt", 64'(illegal_cnt), 64'(0));
        chk("rst in_ready", 64'(in_ready), 64'(1));

        // Back-to-back decode table at full throughput
        cnt = 0;
        in_valid    = 1'b1;
        instruction = vecs[0].instr;
        for (int k = 0; k < NV; k++) begin
            tick();
            chk_out($sformatf("vec%0d", k), vecs[k].imm, vecs[k].fmt, vecs[k].ill);
            if (vecs[k].ill) cnt++;
            chk($sformatf("vec%0d cnt", k), 64'(illegal_cnt), 64'(cnt));
            chk($sformatf("vec%0d in_ready", k), 64'(in_ready), 64'(1));
            if (k + 1 < NV) instruction = vecs[k + 1].instr;
            else in_valid = 1'b0;
        end
        tick();
        chk("drain out_valid", 64'(out_valid), 64'(0));
        chk("drain cnt", 64'(illegal_cnt), 64'(2));

        // Illegal counting and saturation of the narrow counter
        do_reset();
        in_valid    = 1'b1;
        instruction = 32'h00000000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("ill%0d", k), 32'h0, 3'd0, 1'b1);
        end
        instruction = 32'hFFF00093;
        tick();
        chk_out("legal after ill", 32'hFFFFFFFF, 3'd1, 1'b0);
        chk("cnt after 3 ill", 64'(illegal_cnt), 64'(3));
        chk("cnt2 after 3 ill", 64'(illegal_cnt2), 64'(3));
        instruction = 32'h00000000;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        chk("cnt after 5 ill", 64'(illegal_cnt), 64'(5));
        chk("cnt2 saturated", 64'(illegal_cnt2), 64'(3));

        // Backpressure: A held for three stalled cycles, B (illegal) and C follow in order
        do_reset();
        in_valid    = 1'b1;
        instruction = 32'h00100093;
        tick();
        chk_out("stall A", 32'h1, 3'd1, 1'b0);
        out_ready   = 1'b0;
        instruction = 32'h0000007F;
        #1;
`ifdef IMMGEN_SKID_EN
        chk("stall in_ready skid empty", 64'(in_ready), 64'(1));
        tick();
        instruction = 32'h00A12083;
        for (int k = 0; k < 3; k++) begin
            chk_out($sformatf("stall hold%0d", k), 32'h1, 3'd1, 1'b0);
            chk($sformatf("stall in_ready%0d", k), 64'(in_ready), 64'(0));
            if (k < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        chk_out("stall B", 32'h0, 3'd0, 1'b1);
        chk("stall in_ready after drain", 64'(in_ready), 64'(1));
        tick();
        chk_out("stall C", 32'h0000000A, 3'd1, 1'b0);
`else
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall in_ready%0d", k), 64'(in_ready), 64'(0));
            tick();
            chk_out($sformatf("stall hold%0d", k), 32'h1, 3'd1, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall in_ready release", 64'(in_ready), 64'(1));
        tick();
        chk_out("stall B", 32'h0, 3'd0, 1'b1);
        instruction = 32'h00A12083;
        tick();
        chk_out("stall C", 32'h0000000A, 3'd1, 1'b0);
`endif
        in_valid = 1'b0;
        tick();
        chk("stall drain out_valid", 64'(out_valid), 64'(0));
        chk("stall cnt once", 64'(illegal_cnt), 64'(1));

        // Reset while holding a stalled result (and, with skid, a full skid entry)
        in_valid    = 1'b1;
        instruction = 32'h00000000;
        tick();
        out_ready   = 1'b0;
        instruction = 32'h123450B7;
        tick();
        chk("pre-rst out_valid", 64'(out_valid), 64'(1));
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst2 out_valid", 64'(out_valid), 64'(0));
        chk("rst2 cnt", 64'(illegal_cnt), 64'(0));
        chk("rst2 in_ready", 64'(in_ready), 64'(1));
        chk("rst2 imm", 64'(immediate), 64'(0));
        out_ready = 1'b1;
        tick();
        chk("rst2 nothing buffered", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
